// File: rtl/tlul_sram_slave.sv
// ---------------------------------------------------------------------------
// tlul_sram_slave
//
// TL-UL responder backed by a small register-file memory. Accepts one
// Channel A request at a time, services it against the memory and answers
// with a fully registered Channel D beat that is held until the requester
// takes it.
//
// Ports:
//   clk, reset          single clock, asynchronous active-high reset
//   a_valid / a_ready   Channel A handshake (a_ready only in IDLE)
//   a_opcode            0=PutFullData, 1=PutPartialData, 4=Get
//   a_param             ignored
//   a_size              log2 of the transfer size in bytes
//   a_source            requester ID, echoed on d_source
//   a_address           byte address
//   a_mask / a_data     byte-lane write enables and write data
//   d_valid / d_ready   Channel D handshake
//   d_opcode            0=AccessAck, 1=AccessAckData
//   d_param, d_sink     always 0
//   d_size, d_source    echoed from the accepted request
//   d_data              read data (0 for writes and errors)
//   d_error             request was rejected
// ---------------------------------------------------------------------------
module tlul_sram_slave #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int SIZE_WIDTH   = 3,
  parameter int OPCODE_WIDTH = 3,
  parameter int PARAM_WIDTH  = 3,
  parameter int DEPTH        = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [OPCODE_WIDTH-1:0] a_opcode,
  input  logic [PARAM_WIDTH-1:0]  a_param,
  input  logic [SIZE_WIDTH-1:0]   a_size,
  input  logic                    a_source,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic [MASK_WIDTH-1:0]   a_mask,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [OPCODE_WIDTH-1:0] d_opcode,
  output logic [PARAM_WIDTH-1:0]  d_param,
  output logic [SIZE_WIDTH-1:0]   d_size,
  output logic                    d_source,
  output logic                    d_sink,
  output logic [DATA_WIDTH-1:0]   d_data,
  output logic                    d_error
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [OPCODE_WIDTH-1:0] OP_PUT_FULL    = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_PUT_PARTIAL = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_GET         = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ACK         = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_ACK_DATA    = OPCODE_WIDTH'(1);

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  a_fire;
  logic                  d_fire;
  logic [ADDR_WIDTH-1:0] offset;
  logic [IDX_W-1:0]      word_idx;
  logic                  in_range;
  logic                  size_ok;
  logic                  aligned;
  logic                  opcode_ok;
  logic                  full_mask_ok;
  logic                  is_get;
  logic                  is_put;
  logic                  req_error;
  logic [MASK_WIDTH-1:0] lane_mask;
  logic                  unused_bits;

  // a_ready is gated by reset so nothing can be accepted while reset is held
  assign a_ready = (state == IDLE) && !reset;
  assign d_valid = (state == RESP);
  assign a_fire  = a_valid && a_ready;
  assign d_fire  = d_valid && d_ready;

  assign d_param = '0;
  assign d_sink  = 1'b0;

  // Because BASE_ADDR is aligned to the memory size, an address is in range
  // exactly when every offset bit above the word index is zero. Addresses
  // below the base wrap to huge offsets and fail the same test.
  assign offset   = a_address - BASE_ADDR;
  assign in_range = (offset[ADDR_WIDTH-1:IDX_W+2] == '0);
  assign word_idx = offset[IDX_W+1:2];

  assign size_ok   = (a_size <= SIZE_WIDTH'(2));
  assign is_get    = (a_opcode == OP_GET);
  assign is_put    = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PARTIAL);
  assign opcode_ok = is_get || is_put;

  assign unused_bits = ^{a_param, offset[1:0]};

  // Alignment and the lanes a full write must cover both follow from size
  // and the low address bits.
  always_comb begin
    aligned   = 1'b0;
    lane_mask = '1;
    case (a_size)
      SIZE_WIDTH'(0): begin
        aligned   = 1'b1;
        lane_mask = MASK_WIDTH'(1) << a_address[1:0];
      end
      SIZE_WIDTH'(1): begin
        aligned   = !a_address[0];
        lane_mask = MASK_WIDTH'(3) << a_address[1:0];
      end
      SIZE_WIDTH'(2): begin
        aligned   = (a_address[1:0] == 2'b00);
        lane_mask = '1;
      end
      default: begin
        aligned   = 1'b0;
        lane_mask = '1;
      end
    endcase
  end

  assign full_mask_ok = (a_opcode != OP_PUT_FULL) || (a_mask == lane_mask);
  assign req_error    = !in_range || !size_ok || !aligned || !opcode_ok || !full_mask_ok;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one request in flight, held in RESP until taken
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (a_fire) state_next = RESP;
      RESP:    if (d_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Response fields are captured once at A-fire and then held untouched
  // for as long as the requester stalls d_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_opcode <= '0;
      d_size   <= '0;
      d_source <= 1'b0;
      d_data   <= '0;
      d_error  <= 1'b0;
    end else if (a_fire) begin
      d_opcode <= is_get ? OP_ACK_DATA : OP_ACK;
      d_size   <= a_size;
      d_source <= a_source;
      d_error  <= req_error;
      d_data   <= (is_get && !req_error) ? mem[word_idx] : '0;
    end
  end

  // Byte-lane writes happen on the A-fire edge; errored requests never
  // touch memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (a_fire && is_put && !req_error) begin
      for (int b = 0; b < MASK_WIDTH; b++) begin
        if (a_mask[b]) begin
          mem[word_idx][8*b +: 8] <= a_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_tlul_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_tlul_sram_slave
//
// Self-checking bench for tlul_sram_slave. Directed scenarios first, then
// reset-in-response, randomized single transactions and a back-to-back run
// with a_valid held high. Expected responses come from a byte-level memory
// model driven by the protocol rules.
// ---------------------------------------------------------------------------
module tb_tlul_sram_slave;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [2:0]  a_size;
  logic        a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [2:0]  d_param;
  logic [2:0]  d_size;
  logic        d_source;
  logic        d_sink;
  logic [31:0] d_data;
  logic        d_error;

  int vectors;
  int miscompares;

  logic [31:0] mem_model [DEPTH];

  typedef struct {
    bit          err;
    logic [2:0]  op;
    logic [31:0] data;
    logic [2:0]  size;
    bit          src;
  } exp_t;

  exp_t expq[$];

  tlul_sram_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MASK_WIDTH(4), .SIZE_WIDTH(3),
    .OPCODE_WIDTH(3), .PARAM_WIDTH(3), .DEPTH(DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
    .a_param(a_param), .a_size(a_size), .a_source(a_source),
    .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
    .d_param(d_param), .d_size(d_size), .d_source(d_source),
    .d_sink(d_sink), .d_data(d_data), .d_error(d_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Protocol-level reference: decides error/opcode/data and updates memory
  task automatic modelAccess(input logic [2:0] op, input logic [2:0] size,
                             input logic [31:0] addr, input logic [3:0] mask,
                             input logic [31:0] data, output bit err,
                             output logic [2:0] dop, output logic [31:0] ddata);
    longint unsigned la;
    int nbytes, lo, idx;
    logic [3:0] need;
    la  = addr;
    err = 0;
    if (la < longint'(BASE) || la >= longint'(BASE) + DEPTH * 4) err = 1;
    if (size > 2) err = 1;
    else begin
      nbytes = 1 << size;
      if ((addr % nbytes) != 0) err = 1;
      if (op == 0) begin
        lo   = addr % 4;
        need = 4'b0000;
        for (int b = 0; b < 4; b++) if (b >= lo && b < lo + nbytes) need[b] = 1'b1;
        if (mask != need) err = 1;
      end
    end
    if (!(op == 0 || op == 1 || op == 4)) err = 1;
    dop   = (op == 4) ? 3'd1 : 3'd0;
    ddata = 32'h0;
    if (!err) begin
      idx = int'((la - longint'(BASE)) / 4);
      if (op == 4) ddata = mem_model[idx];
      else
        for (int b = 0; b < 4; b++)
          if (mask[b]) mem_model[idx][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic genRandom(output logic [2:0] op, output logic [2:0] size,
                           output logic [31:0] addr, output logic [3:0] mask,
                           output logic [31:0] data);
    int r, off, tmp;
    logic [2:0] odd_ops [5];
    odd_ops = '{3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
    r = $urandom_range(0, 9);
    if (r <= 3) op = 3'd0;
    else if (r <= 5) op = 3'd1;
    else if (r <= 8) op = 3'd4;
    else op = odd_ops[$urandom_range(0, 4)];
    r = $urandom_range(0, 7);
    size = (r == 0) ? 3'd0 : (r == 1) ? 3'd1 : (r == 2) ? 3'd3 : 3'd2;
    off = $urandom_range(0, 3);
    if (size >= 2 && $urandom_range(0, 3) != 0) off = 0;
    if (size == 1 && $urandom_range(0, 3) != 0) off = off & 2;
    if ($urandom_range(0, 19) == 0) addr = $urandom;
    else addr = BASE + 32'($urandom_range(0, DEPTH - 1) * 4 + off);
    if ($urandom_range(0, 3) != 0) begin
      tmp  = ((1 << (1 << size)) - 1) << off;
      mask = tmp[3:0];
    end else begin
      mask = 4'($urandom_range(0, 15));
    end
    data = $urandom;
  endtask

  // One complete transaction; called near a negedge, returns at a negedge
  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] size,
                               input bit src, input logic [31:0] addr,
                               input logic [3:0] mask, input logic [31:0] data,
                               input int hold);
    bit eerr;
    logic [2:0] eop;
    logic [31:0] edata;
    int waited;
    a_valid   = 1'b1;
    a_opcode  = op;
    a_size    = size;
    a_source  = src;
    a_address = addr;
    a_mask    = mask;
    a_data    = data;
    a_param   = 3'($urandom);
    d_ready   = 1'b0;
    waited    = 0;
    while (!a_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("a_ready_before_fire", a_ready, 1);
    modelAccess(op, size, addr, mask, data, eerr, eop, edata);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    checkOutput("d_valid_after_fire", d_valid, 1);
    checkOutput("a_ready_in_resp", a_ready, 0);
    checkOutput("d_opcode", d_opcode, eop);
    checkOutput("d_error", d_error, eerr);
    checkOutput("d_data", d_data, edata);
    checkOutput("d_size", d_size, size);
    checkOutput("d_source", d_source, src);
    checkOutput("d_param", d_param, 0);
    checkOutput("d_sink", d_sink, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("hold_d_valid", d_valid, 1);
      checkOutput("hold_a_ready", a_ready, 0);
      checkOutput("hold_d_data", d_data, edata);
      checkOutput("hold_d_opcode", d_opcode, eop);
      checkOutput("hold_d_error", d_error, eerr);
      checkOutput("hold_d_source", d_source, src);
    end
    @(negedge clk);
    d_ready = 1'b1;
    @(posedge clk);
    #1;
    d_ready = 1'b0;
    checkOutput("d_valid_after_dfire", d_valid, 0);
    checkOutput("a_ready_after_dfire", a_ready, 1);
    @(negedge clk);
  endtask

  initial begin
    logic [2:0]  op, size;
    logic [31:0] addr, data;
    logic [3:0]  mask;
    bit          eerr;
    logic [2:0]  eop;
    logic [31:0] edata;
    exp_t        e;
    int          waited, last_fire, nfire, ndfire;
    bit          fire, dfire;

    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < DEPTH; i++) mem_model[i] = 32'h0;
    reset     = 1'b1;
    a_valid   = 1'b0;
    a_opcode  = 3'd0;
    a_param   = 3'd0;
    a_size    = 3'd0;
    a_source  = 1'b0;
    a_address = 32'h0;
    a_mask    = 4'h0;
    a_data    = 32'h0;
    d_ready   = 1'b0;

    #1;
    checkOutput("reset_a_ready", a_ready, 0);
    checkOutput("reset_d_valid", d_valid, 0);
    checkOutput("reset_d_data", d_data, 0);
    checkOutput("reset_d_error", d_error, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("idle_a_ready", a_ready, 1);
    @(negedge clk);

    $display("[TB] directed transactions");
    applyStimulus(3'd0, 3'd2, 1'b1, BASE + 32'h8, 4'hF, 32'hDEADBEEF, 0);
    applyStimulus(3'd4, 3'd2, 1'b0, BASE + 32'h8, 4'h0, 32'h0, 0);
    applyStimulus(3'd1, 3'd0, 1'b1, BASE + 32'h8, 4'b0100, 32'h0055_0000, 0);
    applyStimulus(3'd4, 3'd2, 1'b1, BASE + 32'h8, 4'hF, 32'h0, 0);
    applyStimulus(3'd4, 3'd2, 1'b0, BASE + 32'h40, 4'hF, 32'h0, 0);
    applyStimulus(3'd0, 3'd2, 1'b0, BASE + 32'h6, 4'hF, 32'h1234_5678, 0);
    applyStimulus(3'd4, 3'd2, 1'b0, BASE + 32'h4, 4'hF, 32'h0, 0);
    applyStimulus(3'd2, 3'd2, 1'b1, BASE + 32'h8, 4'hF, 32'hAAAA_5555, 0);
    applyStimulus(3'd0, 3'd1, 1'b0, BASE + 32'hC, 4'hF, 32'hCAFE_F00D, 0);
    applyStimulus(3'd1, 3'd2, 1'b1, BASE + 32'hC, 4'h0, 32'hFFFF_FFFF, 0);
    applyStimulus(3'd0, 3'd1, 1'b1, BASE + 32'h3C, 4'b1100, 32'hBEEF_0000, 0);
    applyStimulus(3'd4, 3'd2, 1'b1, BASE + 32'h3C, 4'h0, 32'h0, 0);
    applyStimulus(3'd4, 3'd2, 1'b0, BASE + 32'h8, 4'h0, 32'h0, 5);

    $display("[TB] reset while response pending");
    a_valid   = 1'b1;
    a_opcode  = 3'd4;
    a_size    = 3'd2;
    a_address = BASE + 32'h8;
    a_source  = 1'b1;
    d_ready   = 1'b0;
    waited    = 0;
    while (!a_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("rst_a_ready_before_fire", a_ready, 1);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    checkOutput("rst_d_valid_pending", d_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_d_valid_dropped", d_valid, 0);
    checkOutput("rst_a_ready_low", a_ready, 0);
    checkOutput("rst_d_data_cleared", d_data, 0);
    for (int i = 0; i < DEPTH; i++) mem_model[i] = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_a_ready_released", a_ready, 1);
    @(negedge clk);
    applyStimulus(3'd4, 3'd2, 1'b0, BASE + 32'h8, 4'h0, 32'h0, 0);
    applyStimulus(3'd4, 3'd2, 1'b1, BASE + 32'h3C, 4'h0, 32'h0, 0);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 40; n++) begin
      genRandom(op, size, addr, mask, data);
      applyStimulus(op, size, 1'($urandom), addr, mask, data, $urandom_range(0, 2));
    end

    $display("[TB] back-to-back with a_valid held high");
    d_ready   = 1'b1;
    genRandom(op, size, addr, mask, data);
    a_opcode  = op;
    a_size    = size;
    a_address = addr;
    a_mask    = mask;
    a_data    = data;
    a_source  = 1'($urandom);
    a_valid   = 1'b1;
    last_fire = -10;
    nfire     = 0;
    ndfire    = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      fire  = a_valid && a_ready;
      dfire = d_valid && d_ready;
      if (dfire) begin
        ndfire++;
        checkOutput("b2b_dfire_expected", 32'(expq.size() > 0), 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          checkOutput("b2b_d_opcode", d_opcode, e.op);
          checkOutput("b2b_d_error", d_error, e.err);
          checkOutput("b2b_d_data", d_data, e.data);
          checkOutput("b2b_d_size", d_size, e.size);
          checkOutput("b2b_d_source", d_source, e.src);
        end
      end
      if (fire) begin
        checkOutput("b2b_fire_spacing", 32'(cyc - last_fire >= 2), 1);
        modelAccess(a_opcode, a_size, a_address, a_mask, a_data, eerr, eop, edata);
        e.err  = eerr;
        e.op   = eop;
        e.data = edata;
        e.size = a_size;
        e.src  = a_source;
        expq.push_back(e);
        last_fire = cyc;
        nfire++;
      end
      @(posedge clk);
      #1;
      if (fire) begin
        if (nfire < 12) begin
          genRandom(op, size, addr, mask, data);
          a_opcode  = op;
          a_size    = size;
          a_address = addr;
          a_mask    = mask;
          a_data    = data;
          a_source  = 1'($urandom);
        end else begin
          a_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    d_ready = 1'b0;
    checkOutput("b2b_a_fire_count", nfire, 12);
    checkOutput("b2b_d_fire_count", ndfire, 12);
    checkOutput("b2b_queue_drained", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tlul_sram_slave.md
Name: tlul_sram_slave

Overview:
- TL-UL responder (slave endpoint) that terminates Channel A requests from the peripheral crossbar's slave-side port and returns Channel D responses.
- Backed by a DEPTH x DATA_WIDTH register-file memory.
- Used as the default peripheral target and as the reference responder in interconnect simulation.
- One transaction outstanding at a time; fully registered D channel.

Parameters:
- ADDR_WIDTH, 32, Channel A address width
- DATA_WIDTH, 32, data width; only 32 is supported
- MASK_WIDTH, DATA_WIDTH/8, byte-lane mask width
- SIZE_WIDTH, 3, TL-UL size field width (log2 bytes)
- OPCODE_WIDTH, 3, opcode width
- PARAM_WIDTH, 3, param width
- DEPTH, 16, number of 32-bit words; power of 2, minimum 2
- BASE_ADDR, 32'h0000_0000, byte base address; must be aligned to DEPTH*4

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- a_valid  in  1  Channel A request valid
- a_ready  out  1  slave can accept a request
- a_opcode  in  OPCODE_WIDTH  0=PutFullData, 1=PutPartialData, 4=Get
- a_param  in  PARAM_WIDTH  ignored
- a_size  in  SIZE_WIDTH  log2 of transfer bytes
- a_source  in  1  requester ID
- a_address  in  ADDR_WIDTH  byte address
- a_mask  in  MASK_WIDTH  byte-lane write enables
- a_data  in  DATA_WIDTH  write data
- d_valid  out  1  response valid
- d_ready  in  1  response accepted
- d_opcode  out  OPCODE_WIDTH  0=AccessAck, 1=AccessAckData
- d_param  out  PARAM_WIDTH  always 0
- d_size  out  SIZE_WIDTH  echo of a_size
- d_source  out  1  echo of a_source
- d_sink  out  1  always 0
- d_data  out  DATA_WIDTH  read data; 0 for writes and errors
- d_error  out  1  request was in error

Behaviour:
- Reset (async assert, sync release): all D outputs 0, a_ready=0 while reset is high, FSM=IDLE, memory cleared to 0.
- FSM has two states: IDLE and RESP.
- IDLE: a_ready=1, d_valid=0. An A-fire (a_valid & a_ready) captures the request and moves to RESP on the next edge.
- Latency: A-fire on edge N → d_valid=1 after edge N; minimum one bubble cycle between requests.
- RESP: a_ready=0, d_valid=1. All D fields stay stable until D-fire (d_valid & d_ready), which returns to IDLE.
  - d_ready held low keeps RESP indefinitely with no field change.
- a_ready is not asserted in the D-fire cycle (no same-cycle turnaround).
- Word index = (a_address - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits after the range check.
- Error conditions (any one sets d_error=1; no memory write; d_data=0):
  - address outside [BASE_ADDR, BASE_ADDR + DEPTH*4)
  - a_size > 2
  - address not aligned to 2^a_size
  - opcode not in {0, 1, 4}
  - PutFullData with a mask that is not exactly the contiguous lanes covered by size/address[1:0]
- Write (opcode 0/1, no error): on the A-fire edge, byte lane i is written iff a_mask[i]. Mask 0 for PutPartialData is a legal no-op. Response d_opcode=0.
- Read (opcode 4, no error): d_data = full 32-bit word, sampled at the A-fire edge; a_mask ignored. d_opcode=1.
- d_opcode on error: 1 for Get, 0 for every other opcode, including unsupported ones.
- d_size, d_source: captured from the A request. d_param=0 and d_sink=0 always.
- Reset during RESP: the response is dropped and d_valid clears immediately (asynchronous). Memory is cleared.
- Inputs in IDLE without a_valid have no effect; a_param is never checked.

Test Plan:
- Reset then PutFullData addr=BASE+0x8, size=2, mask=4'hF, data=32'hDEADBEEF, d_ready=1 → d_valid one cycle after A-fire with d_opcode=0, d_error=0, d_data=0, d_size=2, d_source echoed; then Get 0x8 → d_opcode=1, d_data=32'hDEADBEEF.
- PutPartialData addr=0x8, size=0, mask=4'b0100, data=32'h0055_0000 over 32'hDEADBEEF → subsequent Get returns 32'hDE55BEEF.
- Get addr=BASE+DEPTH*4 (0x40) → d_error=1, d_opcode=1, d_data=0; Put size=2 addr=0x6 → d_error=1, memory unchanged; opcode=2 → d_error=1, d_opcode=0.
- Get with d_ready held low for 5 cycles → d_valid and all D fields stable and a_ready=0 throughout; D-fire on cycle 6 → a_ready=1 on the following cycle.
- Assert reset while in RESP with d_ready=0 → d_valid=0 immediately; after release a_ready=1, and Get of any address returns 0.
- Back-to-back requests with a_valid held high → A-fires spaced at least 2 cycles apart, with exactly one D-fire per A-fire, in order.
